// File: rtl/game_timer_pkg.sv
// game_timer_pkg: shared types and helpers for the round countdown timer.
//   state_e : FSM state encoding (2-bit)
//   BCD_W   : width of one BCD digit
//   bcd_dec : two-digit BCD decrement that saturates at 00
package game_timer_pkg;

    localparam int unsigned BCD_W = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2,
        StDone  = 2'd3
    } state_e;

    // Returns {tens, ones} decremented by one second; 00 stays 00.
    function automatic logic [2*BCD_W-1:0] bcd_dec(input logic [BCD_W-1:0] tens,
                                                   input logic [BCD_W-1:0] ones);
        logic [2*BCD_W-1:0] res;
        if (ones != '0) begin
            res = {tens, ones - BCD_W'(1)};
        end else if (tens != '0) begin
            res = {tens - BCD_W'(1), BCD_W'(9)};
        end else begin
            res = '0;
        end
        return res;
    endfunction

endpackage

// File: rtl/game_timer_tick_gen.sv
// timer_tick_gen: rising-edge detector on the divided clock plus a 1-second prescaler.
// Ports:
//   i_clk        system clock
//   i_rst_n      asynchronous active-low reset
//   i_slow_clk   divided clock, sampled as data in the i_clk domain
//   i_en         advance the prescaler on detected edges
//   i_sync_clr   synchronously zero the prescaler (wins over i_en)
//   o_sec_step   one-cycle pulse on the TICKS_PER_SEC-th edge
module timer_tick_gen #(
    parameter int unsigned TICKS_PER_SEC = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_slow_clk,
    input  logic i_en,
    input  logic i_sync_clr,
    output logic o_sec_step
);

    localparam int unsigned CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_PER_SEC - 1);

    logic             r_slow_clk_d;
    logic [CNT_W-1:0] r_sub_cnt;
    logic             w_tick;
    logic             w_adv;
    logic             w_last;

    assign w_tick     = i_slow_clk & ~r_slow_clk_d;
    assign w_adv      = i_en & w_tick;
    assign w_last     = (r_sub_cnt == CNT_LAST);
    assign o_sec_step = w_adv & w_last;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_slow_clk_d <= 1'b0;
            r_sub_cnt    <= '0;
        end else begin
            r_slow_clk_d <= i_slow_clk;
            if (i_sync_clr) begin
                r_sub_cnt <= '0;
            end else if (w_adv) begin
                r_sub_cnt <= w_last ? '0 : r_sub_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/game_timer.sv
// game_timer: two-digit BCD round countdown driven by edges of the divided clock.
// Optional feature: define TIMER_WARN_EN to enable the low-time blink on o_warn;
// otherwise o_warn is tied low and no compare logic is built.
// Ports:
//   i_clk        system clock (100 MHz)
//   i_rst_n      asynchronous active-low reset
//   i_slow_clk   divided clock from freqdiv, treated as data
//   i_start      level; begin, or restart from DONE
//   i_pause      level; hold the countdown while high
//   i_clear      level; return to IDLE and reload
//   o_tens       BCD tens digit
//   o_ones       BCD ones digit
//   o_running    high while in RUN
//   o_done       high while in DONE
//   o_time_up    one-cycle pulse when the count reaches 00
//   o_warn       low-time blink (only with TIMER_WARN_EN)
module game_timer
    import game_timer_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 4,
    parameter int unsigned START_SECS    = 30,
    parameter int unsigned WARN_SECS     = 5
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_slow_clk,
    input  logic             i_start,
    input  logic             i_pause,
    input  logic             i_clear,
    output logic [BCD_W-1:0] o_tens,
    output logic [BCD_W-1:0] o_ones,
    output logic             o_running,
    output logic             o_done,
    output logic             o_time_up,
    output logic             o_warn
);

    if (TICKS_PER_SEC < 1) begin : g_bad_tps
        $error("TICKS_PER_SEC must be at least 1");
    end
    if (START_SECS < 1 || START_SECS > 99) begin : g_bad_start
        $error("START_SECS must be in 1..99");
    end
    if (WARN_SECS > 99) begin : g_bad_warn
        $error("WARN_SECS must be in 0..99");
    end

    localparam logic [BCD_W-1:0] START_TENS = BCD_W'(START_SECS / 10);
    localparam logic [BCD_W-1:0] START_ONES = BCD_W'(START_SECS % 10);

    state_e           r_state;
    logic [BCD_W-1:0] r_tens;
    logic [BCD_W-1:0] r_ones;
    logic             r_running;
    logic             r_done;
    logic             r_time_up;
    logic             r_warn;

    state_e           w_state_nxt;
    logic [BCD_W-1:0] w_tens_nxt;
    logic [BCD_W-1:0] w_ones_nxt;
    logic             w_time_up_nxt;
    logic             w_warn_nxt;
    logic             w_sec_step;
    logic             w_is_one;
    logic             w_en;
    logic             w_sync_clr;

    // Prescaler only counts in RUN; it sits at zero in IDLE/DONE so every entry
    // to RUN starts a full second. PAUSE neither counts nor clears.
    assign w_en       = (r_state == StRun);
    assign w_sync_clr = (r_state == StIdle) || (r_state == StDone);

    timer_tick_gen #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_tick_gen (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_slow_clk (i_slow_clk),
        .i_en       (w_en),
        .i_sync_clr (w_sync_clr),
        .o_sec_step (w_sec_step)
    );

    assign w_is_one = (r_tens == '0) && (r_ones == BCD_W'(1));

    always_comb begin
        w_state_nxt   = r_state;
        w_tens_nxt    = r_tens;
        w_ones_nxt    = r_ones;
        w_time_up_nxt = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_clear) begin
                    w_tens_nxt = START_TENS;
                    w_ones_nxt = START_ONES;
                end else if (i_start) begin
                    w_state_nxt = StRun;
                end
            end
            StRun: begin
                if (i_clear) begin
                    w_state_nxt = StIdle;
                    w_tens_nxt  = START_TENS;
                    w_ones_nxt  = START_ONES;
                end else if (w_sec_step && w_is_one) begin
                    w_state_nxt   = StDone;
                    w_tens_nxt    = '0;
                    w_ones_nxt    = '0;
                    w_time_up_nxt = 1'b1;
                end else begin
                    // A second completing in the same cycle as pause still counts.
                    if (w_sec_step) begin
                        {w_tens_nxt, w_ones_nxt} = bcd_dec(r_tens, r_ones);
                    end
                    if (i_pause) begin
                        w_state_nxt = StPause;
                    end
                end
            end
            StPause: begin
                if (i_clear) begin
                    w_state_nxt = StIdle;
                    w_tens_nxt  = START_TENS;
                    w_ones_nxt  = START_ONES;
                end else if (!i_pause) begin
                    w_state_nxt = StRun;
                end
            end
            StDone: begin
                if (i_clear) begin
                    w_state_nxt = StIdle;
                    w_tens_nxt  = START_TENS;
                    w_ones_nxt  = START_ONES;
                end else if (i_start) begin
                    w_state_nxt = StRun;
                    w_tens_nxt  = START_TENS;
                    w_ones_nxt  = START_ONES;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

`ifdef TIMER_WARN_EN
    localparam logic [6:0] WARN_VAL = 7'(WARN_SECS);

    logic [6:0] w_value_bin;

    assign w_value_bin = 7'(r_tens) * 7'd10 + 7'(r_ones);

    // Registering i_slow_clk here gives the same one-cycle-late blink as slow_clk_d.
    assign w_warn_nxt = ((r_state == StRun) || (r_state == StPause)) &&
                        (w_value_bin <= WARN_VAL) ? i_slow_clk : 1'b0;
`else
    assign w_warn_nxt = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= StIdle;
            r_tens    <= START_TENS;
            r_ones    <= START_ONES;
            r_running <= 1'b0;
            r_done    <= 1'b0;
            r_time_up <= 1'b0;
            r_warn    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_tens    <= w_tens_nxt;
            r_ones    <= w_ones_nxt;
            r_running <= (w_state_nxt == StRun);
            r_done    <= (w_state_nxt == StDone);
            r_time_up <= w_time_up_nxt;
            r_warn    <= w_warn_nxt;
        end
    end

    assign o_tens    = r_tens;
    assign o_ones    = r_ones;
    assign o_running = r_running;
    assign o_done    = r_done;
    assign o_time_up = r_time_up;
    assign o_warn    = r_warn;

endmodule

// File: tb/tb_game_timer.sv
// Self-checking bench for game_timer: directed scenarios plus a randomized phase,
// all compared every cycle against a seconds-level behavioural model.
module tb_game_timer;

    localparam int unsigned TPS   = 4;
    localparam int unsigned START = 30;
    localparam int unsigned WARNS = 5;
`ifdef TIMER_WARN_EN
    localparam int unsigned WARN_ON = 1;
`else
    localparam int unsigned WARN_ON = 0;
`endif

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic       clk;
    logic       rst_n;
    logic       slow_clk;
    logic       start;
    logic       pause;
    logic       clear;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       running;
    logic       done;
    logic       time_up;
    logic       warn;

    int n_checks;
    int n_errors;
    int n_tu;

    // Reference model state: plain integers in seconds and ticks.
    int m_state;
    int m_secs;
    int m_sub;
    int m_prev;
    int m_running;
    int m_done;
    int m_time_up;
    int m_warn;

    game_timer #(
        .TICKS_PER_SEC(TPS),
        .START_SECS   (START),
        .WARN_SECS    (WARNS)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_slow_clk(slow_clk),
        .i_start   (start),
        .i_pause   (pause),
        .i_clear   (clear),
        .o_tens    (tens),
        .o_ones    (ones),
        .o_running (running),
        .o_done    (done),
        .o_time_up (time_up),
        .o_warn    (warn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_state   = M_IDLE;
        m_secs    = START;
        m_sub     = 0;
        m_prev    = 0;
        m_running = 0;
        m_done    = 0;
        m_time_up = 0;
        m_warn    = 0;
    endfunction

    function automatic void model_update();
        int tick;
        int sec;
        int nst;
        tick = (slow_clk && (m_prev == 0)) ? 1 : 0;
        sec  = (m_state == M_RUN && tick == 1 && m_sub == TPS - 1) ? 1 : 0;
        m_warn = 0;
        if (WARN_ON == 1 && (m_state == M_RUN || m_state == M_PAUSE) && m_secs <= WARNS)
            m_warn = slow_clk ? 1 : 0;
        m_time_up = 0;
        nst = m_state;
        case (m_state)
            M_IDLE: begin
                if (clear) m_secs = START;
                else if (start) begin nst = M_RUN; m_sub = 0; end
            end
            M_RUN: begin
                if (clear) begin
                    nst = M_IDLE; m_secs = START; m_sub = 0;
                end else begin
                    if (tick == 1) m_sub = (sec == 1) ? 0 : m_sub + 1;
                    if (sec == 1 && m_secs == 1) begin
                        nst = M_DONE; m_secs = 0; m_time_up = 1;
                    end else begin
                        if (sec == 1) m_secs = m_secs - 1;
                        if (pause) nst = M_PAUSE;
                    end
                end
            end
            M_PAUSE: begin
                if (clear) begin nst = M_IDLE; m_secs = START; m_sub = 0; end
                else if (!pause) nst = M_RUN;
            end
            default: begin
                if (clear) begin nst = M_IDLE; m_secs = START; m_sub = 0; end
                else if (start) begin nst = M_RUN; m_secs = START; m_sub = 0; end
            end
        endcase
        m_prev    = slow_clk ? 1 : 0;
        m_state   = nst;
        m_running = (nst == M_RUN) ? 1 : 0;
        m_done    = (nst == M_DONE) ? 1 : 0;
    endfunction

    function automatic int unsigned model_vec();
        return ((m_secs / 10) << 8) | ((m_secs % 10) << 4) | (m_running << 3) |
               (m_done << 2) | (m_time_up << 1) | m_warn;
    endfunction

    function automatic int unsigned dut_vec();
        return {20'd0, tens, ones, running, done, time_up, warn};
    endfunction

    function automatic int unsigned bcd();
        return {24'd0, tens, ones};
    endfunction

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic step();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_update();
        #1;
        if (time_up) n_tu++;
        check("cycle", dut_vec(), model_vec());
        @(negedge clk);
    endtask

    // n rising edges of slow_clk, each high two cycles then low two cycles.
    task automatic edges(input int n);
        for (int i = 0; i < n; i++) begin
            slow_clk = 1'b1; step(); step();
            slow_clk = 1'b0; step(); step();
        end
    endtask

    initial begin
        n_checks = 0; n_errors = 0; n_tu = 0;
        rst_n = 1'b0; slow_clk = 1'b0; start = 1'b0; pause = 1'b0; clear = 1'b0;
        model_reset();
        @(negedge clk);

        // Reset with slow_clk toggling.
        for (int i = 0; i < 6; i++) begin
            slow_clk = ~slow_clk;
            step();
        end
        check("rst_value", bcd(), 32'h30);
        check("rst_flags", {running, done, time_up, warn}, 0);
        slow_clk = 1'b0;
        rst_n = 1'b1;
        step();
        edges(3);
        check("idle_no_dec", bcd(), 32'h30);
        check("idle_not_running", running, 0);

        // First second: 3 edges hold, 4th decrements.
        start = 1'b1; step(); start = 1'b0;
        check("start_running", running, 1);
        edges(3);
        check("three_edges", bcd(), 32'h30);
        edges(1);
        check("four_edges", bcd(), 32'h29);
        edges(36);
        check("at_20", bcd(), 32'h20);
        edges(4);
        check("borrow_19", bcd(), 32'h19);

        // Pause mid-second keeps prescaler progress.
        edges(2);
        pause = 1'b1; step();
        edges(10);
        check("paused_value", bcd(), 32'h19);
        check("paused_not_running", running, 0);
        pause = 1'b0; step(); step();
        edges(2);
        check("pause_resume", bcd(), 32'h18);

        // Pause on the completing edge still decrements.
        edges(3);
        pause = 1'b1;
        edges(1);
        check("pause_with_step", bcd(), 32'h17);
        check("pause_with_step_state", {running, done}, 0);
        pause = 1'b0; step();
        check("resume_running", running, 1);

        // clear beats start in RUN.
        clear = 1'b1; start = 1'b1; step();
        clear = 1'b0; start = 1'b0;
        check("clear_reload", bcd(), 32'h30);
        check("clear_idle", {running, done}, 0);

        // Full countdown to DONE.
        n_tu = 0;
        start = 1'b1; step(); start = 1'b0;
        edges(119);
        check("at_01", bcd(), 32'h01);
        check("no_early_timeup", n_tu, 0);
        edges(1);
        check("at_00", bcd(), 32'h00);
        check("timeup_once", n_tu, 1);
        check("done_flags", {running, done}, 32'h1);
        edges(8);
        check("hold_00", bcd(), 32'h00);
        check("timeup_still_once", n_tu, 1);

        // Restart from DONE.
        start = 1'b1; step(); start = 1'b0;
        check("restart_value", bcd(), 32'h30);
        check("restart_running", running, 1);
        edges(3);
        check("restart_three", bcd(), 32'h30);
        edges(1);
        check("restart_four", bcd(), 32'h29);

        // Warning window.
        edges(92);
        check("at_06", bcd(), 32'h06);
        slow_clk = 1'b1; step();
        check("warn_at_06", warn, 0);
        slow_clk = 1'b0; step(); step();
        edges(3);
        check("at_05", bcd(), 32'h05);
        slow_clk = 1'b1; step();
        check("warn_at_05_high", warn, WARN_ON);
        slow_clk = 1'b0; step();
        check("warn_at_05_low", warn, 0);
        edges(19);
        check("warn_done_value", bcd(), 32'h00);
        check("warn_done_state", done, 1);
        step(); step();
        check("warn_in_done", warn, 0);

        // Randomized phase against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(2) == 0) slow_clk = ~slow_clk;
            start = ($urandom_range(39) == 0);
            clear = ($urandom_range(249) == 0);
            if ($urandom_range(49) == 0) pause = ~pause;
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
